lisnoc_vc_link_arbiter: RTL and testbench
=========================================

# lisnoc_vc_link_arbiter

Sender-side virtual-channel scheduler for one LISNoC link. It shares the single physical flit bus of an outbound link between `vchannels` per-VC output buffers. Each cycle it picks one VC that has a flit and whose downstream receiver signals ready, drives that flit and the VC's valid bit, and pops the buffer. It sits between the per-VC output FIFOs of a router output port and the link's `out` side.

## Interface
- `data_width`, 32, payload bits per flit
- `type_width`, 2, flit type bits; they are the MSBs of each flit
- `vchannels`, 3, number of virtual channels (≥1)

Flit width `FW = data_width+type_width`.

- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-low reset
- `in_flit`  in  vchannels*FW  per-VC head-of-buffer flit; VC v occupies bits [v*FW +: FW]
- `in_valid`  in  vchannels  VC v buffer holds a flit
- `in_ready`  out  vchannels  one-hot pop; VC v flit is consumed this cycle
- `link_flit`  out  FW  flit on the link
- `link_valid`  out  vchannels  one-hot valid for the selected VC
- `link_ready`  in  vchannels  receiver can accept on VC v

## Operation
- Flit types, from bits [FW-1 -: 2]:
  - 00 = PAYLOAD
  - 01 = HEADER
  - 10 = LAST
  - 11 = SINGLE
- Eligibility: `elig[v] = in_valid[v] & link_ready[v]`, further masked by the lock when the lock feature is active.
- Grant is round-robin. Starting at VC `prio` and wrapping, the first eligible VC wins. `grant` is one-hot, or zero if no VC is eligible.
- Outputs:
  - `link_valid = grant`
  - `in_ready = grant`
  - `link_flit = in_flit` of the granted VC; all zeros when `grant == 0`
- A transfer is defined as `grant != 0`. By construction it is always accepted, because ready is already included in eligibility.
- `prio` update on transfer from VC g: `prio <= (g == vchannels-1) ? 0 : g+1`. The arithmetic is mod `vchannels`, and `prio` is $clog2(vchannels) bits wide (minimum 1).
- No transfer: `prio` holds.
- `vchannels == 1`: the block degenerates to a pass-through gated by `in_valid[0] & link_ready[0]`.
- Only one VC is ever valid per cycle, which satisfies the link rule that the flit wires carry data for the single set valid bit.

## Timing
- Zero latency: the path from `in_valid`/`link_ready`/`in_flit` to `link_*`/`in_ready` is combinational. State changes only at the clock edge after a transfer.
- While `rst == 0`:
  - `link_valid = 0`, `in_ready = 0`, `link_flit = 0`
  - at the edge: `prio <= 0`, lock cleared
- First possible grant is in the cycle `rst` is high.
- Reset asserted mid-packet aborts any lock. The arbiter has no flit storage, so nothing is lost or duplicated in the arbiter itself.
- `link_ready[v]` dropping while VC v is pending causes v to be skipped this cycle. `prio` is unaffected.
- Simultaneous eligibility of all VCs gives strict rotation: 0, 1, 2, 0, …

## Configuration
Macro: `LISNOC_VC_LINK_PKT_LOCK_EN`.

- **Undefined (default):** flit-level interleaving. Every transfer may come from a different VC, and `prio` advances on every transfer.
- **Defined:** packet-atomic link. Extra state is `lock` (1 bit) and `lock_vc`.
  - Transfer of a HEADER from VC g: `lock <= 1`, `lock_vc <= g`; `prio` holds.
  - While `lock`, eligibility is restricted to `lock_vc`. If that VC is not eligible, the cycle idles even when other VCs are ready.
  - Transfer of a LAST from `lock_vc`: `lock <= 0`, and `prio` advances past `lock_vc`.
  - SINGLE: no lock is taken, and `prio` advances.
  - PAYLOAD while unlocked: treated like SINGLE.
  - HEADER while locked cannot occur from `lock_vc` (protocol error). The lock is retained and `lock_vc` is unchanged.

## Test plan
1. **Reset.** Hold `rst = 0` with all `in_valid = 3'b111`, `link_ready = 3'b111` → `link_valid = 0`, `in_ready = 0`, `link_flit = 0`. Release → first grant is VC0.
2. **Round robin.** `vchannels = 3`, all valid/ready for 6 cycles → `link_valid` = 001, 010, 100, 001, 010, 100; `link_flit` matches each VC's data (e.g. 0x0_AAAA0000, 0x0_BBBB0000, 0x0_CCCC0000).
3. **Backpressure skip.** `prio = 1`, `in_valid = 111`, `link_ready = 101` → grant VC2, next `prio = 0`. Then `link_ready = 000` → `link_valid = 0`, `prio` stays 0.
4. **Single eligible.** Only VC1 valid/ready for 4 cycles → VC1 granted every cycle, each flit popped once (`in_ready = 010` each cycle).
5. **Lock feature, `_EN` defined.** VC0 sends HEADER, PAYLOAD, LAST. VC1 is continuously valid/ready but VC0 stalls one cycle mid-packet → that cycle `link_valid = 0`. VC1 is granted only after VC0's LAST. Without the macro → VC1 interleaves at the first cycle following VC0's HEADER.
6. **Reset mid-packet, lock enabled.** VC2 sends HEADER, then `rst = 0` for one cycle, then all VCs valid → grant VC0 (lock cleared, `prio = 0`).

Source files
------------

// File: rtl/lisnoc_vc_link_arbiter.sv
// Round-robin virtual-channel scheduler for one LISNoC outbound link (zero-latency grant).
// Define LISNOC_VC_LINK_PKT_LOCK_EN to keep the link on one VC from HEADER through LAST.
module lisnoc_vc_link_arbiter #(
    parameter int unsigned data_width = 32,
    parameter int unsigned type_width = 2,
    parameter int unsigned vchannels  = 3
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [vchannels*(data_width+type_width)-1:0] in_flit,
    input  logic [vchannels-1:0]                     in_valid,
    output logic [vchannels-1:0]                     in_ready,
    output logic [data_width+type_width-1:0]         link_flit,
    output logic [vchannels-1:0]                     link_valid,
    input  logic [vchannels-1:0]                     link_ready
);

    localparam int unsigned FW = data_width + type_width;
    localparam int unsigned PW = (vchannels > 1) ? $clog2(vchannels) : 1;

    logic [PW-1:0]        prio;
    logic [PW-1:0]        gidx;
    logic [PW-1:0]        prio_adv;
    logic [vchannels-1:0] elig;
    logic [vchannels-1:0] grant;
    logic                 transfer;

`ifdef LISNOC_VC_LINK_PKT_LOCK_EN
    localparam logic [1:0] FLIT_HEADER = 2'b01;
    localparam logic [1:0] FLIT_LAST   = 2'b10;

    logic                 lock;
    logic [PW-1:0]        lock_vc;
    logic [vchannels-1:0] lock_mask;
    logic [1:0]           ftype;

    // While a packet is in flight only its VC may use the link.
    always_comb begin
        lock_mask = '1;
        if (lock) begin
            lock_mask = vchannels'(1) << lock_vc;
        end
    end

    always_comb begin
        elig = in_valid & link_ready & {vchannels{rst}} & lock_mask;
    end

    always_comb begin
        ftype = link_flit[FW-1 -: 2];
    end
`else
    always_comb begin
        elig = in_valid & link_ready & {vchannels{rst}};
    end
`endif

    // First eligible VC at or after prio, wrapping modulo vchannels.
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        logic          found;
        grant = '0;
        gidx  = '0;
        sum   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(vchannels); i++) begin
            sum = {1'b0, prio} + (PW+1)'(i);
            if (sum >= (PW+1)'(vchannels)) begin
                sum = sum - (PW+1)'(vchannels);
            end
            idx = sum[PW-1:0];
            if (!found && elig[idx]) begin
                grant[idx] = 1'b1;
                gidx       = idx;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        link_flit = '0;
        for (int v = 0; v < int'(vchannels); v++) begin
            if (grant[v]) begin
                link_flit = link_flit | in_flit[v*FW +: FW];
            end
        end
    end

    always_comb begin
        transfer   = |grant;
        link_valid = grant;
        in_ready   = grant;
        prio_adv   = (gidx == PW'(vchannels - 1)) ? '0 : gidx + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prio    <= '0;
`ifdef LISNOC_VC_LINK_PKT_LOCK_EN
            lock    <= 1'b0;
            lock_vc <= '0;
`endif
        end else if (transfer) begin
`ifdef LISNOC_VC_LINK_PKT_LOCK_EN
            // A stray HEADER inside a locked packet keeps the existing lock.
            if (lock) begin
                if (ftype == FLIT_LAST) begin
                    lock <= 1'b0;
                    prio <= prio_adv;
                end
            end else if (ftype == FLIT_HEADER) begin
                lock    <= 1'b1;
                lock_vc <= gidx;
            end else begin
                prio <= prio_adv;
            end
`else
            prio <= prio_adv;
`endif
        end
    end

endmodule

// File: tb/tb_lisnoc_vc_link_arbiter.sv
// Directed self-checking bench for lisnoc_vc_link_arbiter (3 VCs, 32+2 bit flits).
module tb_lisnoc_vc_link_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned TW = 2;
    localparam int unsigned VC = 3;
    localparam int unsigned FW = DW + TW;

    logic              clk;
    logic              rst;
    logic [VC*FW-1:0]  in_flit;
    logic [VC-1:0]     in_valid;
    logic [VC-1:0]     in_ready;
    logic [FW-1:0]     link_flit;
    logic [VC-1:0]     link_valid;
    logic [VC-1:0]     link_ready;

    logic [FW-1:0] f0, f1, f2;
    int tests;
    int fails;

    assign in_flit = {f2, f1, f0};

    lisnoc_vc_link_arbiter #(
        .data_width(DW),
        .type_width(TW),
        .vchannels (VC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .link_flit (link_flit),
        .link_valid(link_valid),
        .link_ready(link_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [31:0] d);
        return {t, d};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive, let combinational outputs settle, then check all three outputs.
    task automatic drive_check(input string tag, input logic [VC-1:0] v, input logic [VC-1:0] r,
                               input logic [VC-1:0] exp_g, input logic [FW-1:0] exp_f);
        in_valid   = v;
        link_ready = r;
        #1;
        check({tag, ".link_valid"}, 64'(link_valid), 64'(exp_g));
        check({tag, ".in_ready"},   64'(in_ready),   64'(exp_g));
        check({tag, ".link_flit"},  64'(link_flit),  64'(exp_f));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [VC-1:0] rr_exp [6];
        logic [FW-1:0] rr_flit [6];
        tests = 0;
        fails = 0;
        rst = 1'b0;
        in_valid = '0;
        link_ready = '0;
        f0 = mk(2'b00, 32'hAAAA_0000);
        f1 = mk(2'b00, 32'hBBBB_0000);
        f2 = mk(2'b00, 32'hCCCC_0000);

        // 1. reset gates outputs even with everything valid/ready
        drive_check("reset", 3'b111, 3'b111, 3'b000, '0);
        tick();
        drive_check("reset2", 3'b111, 3'b111, 3'b000, '0);
        tick();
        rst = 1'b1;

        // 2. strict rotation
        rr_exp  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        rr_flit = '{mk(2'b00, 32'hAAAA_0000), mk(2'b00, 32'hBBBB_0000), mk(2'b00, 32'hCCCC_0000),
                    mk(2'b00, 32'hAAAA_0000), mk(2'b00, 32'hBBBB_0000), mk(2'b00, 32'hCCCC_0000)};
        for (int i = 0; i < 6; i++) begin
            drive_check($sformatf("rr%0d", i), 3'b111, 3'b111, rr_exp[i], rr_flit[i]);
            tick();
        end

        // 3. backpressure skip: move prio to 1, then VC1 not ready
        drive_check("bp_pre", 3'b111, 3'b111, 3'b001, f0);
        tick();
        drive_check("bp_skip", 3'b111, 3'b101, 3'b100, f2);
        tick();
        drive_check("bp_none", 3'b111, 3'b000, 3'b000, '0);
        tick();
        drive_check("bp_prio0", 3'b111, 3'b111, 3'b001, f0);
        tick();

        // 4. only VC1 eligible, fresh flit each cycle
        for (int i = 0; i < 4; i++) begin
            f1 = mk(2'b00, 32'hBBBB_0000 + 32'(i));
            drive_check($sformatf("single%0d", i), 3'b010, 3'b010, 3'b010,
                        mk(2'b00, 32'hBBBB_0000 + 32'(i)));
            tick();
        end

        // 5. packet from VC0 while VC1 is always ready
        rst = 1'b0;
        in_valid = '0;
        tick();
        rst = 1'b1;
        f1 = mk(2'b00, 32'h1111_1111);
        f0 = mk(2'b01, 32'h0000_0001);
        drive_check("pkt_hdr", 3'b011, 3'b011, 3'b001, mk(2'b01, 32'h0000_0001));
        tick();
        f0 = mk(2'b00, 32'h0000_0002);
`ifdef LISNOC_VC_LINK_PKT_LOCK_EN
        drive_check("pkt_pay", 3'b011, 3'b011, 3'b001, mk(2'b00, 32'h0000_0002));
        tick();
        drive_check("pkt_stall", 3'b010, 3'b011, 3'b000, '0);
        tick();
        f0 = mk(2'b10, 32'h0000_0003);
        drive_check("pkt_last", 3'b011, 3'b011, 3'b001, mk(2'b10, 32'h0000_0003));
        tick();
        drive_check("pkt_vc1", 3'b010, 3'b011, 3'b010, mk(2'b00, 32'h1111_1111));
        tick();
`else
        drive_check("pkt_intlv", 3'b011, 3'b011, 3'b010, mk(2'b00, 32'h1111_1111));
        tick();
        drive_check("pkt_stall", 3'b010, 3'b011, 3'b010, mk(2'b00, 32'h1111_1111));
        tick();
        f0 = mk(2'b10, 32'h0000_0003);
        drive_check("pkt_last", 3'b011, 3'b011, 3'b001, mk(2'b10, 32'h0000_0003));
        tick();
`endif

        // 6. reset in the middle of a VC2 packet
        rst = 1'b0;
        in_valid = '0;
        tick();
        rst = 1'b1;
        f0 = mk(2'b00, 32'hAAAA_0000);
        f1 = mk(2'b00, 32'hBBBB_0000);
        f2 = mk(2'b01, 32'hCCCC_0001);
        drive_check("mid_hdr", 3'b100, 3'b111, 3'b100, mk(2'b01, 32'hCCCC_0001));
        tick();
        rst = 1'b0;
        drive_check("mid_rst", 3'b111, 3'b111, 3'b000, '0);
        tick();
        rst = 1'b1;
        drive_check("mid_after", 3'b111, 3'b111, 3'b001, mk(2'b00, 32'hAAAA_0000));
        tick();
        drive_check("mid_next", 3'b111, 3'b111, 3'b010, mk(2'b00, 32'hBBBB_0000));
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
